// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port unified memory between instruction fetch and the MEM stage.
// Optional ROUND_ROBIN_EN: alternate grants on contention instead of fixed DATA-over-FETCH priority.
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddress,
    output logic [DATA_W-1:0] ifData,
    output logic              ifReady,
    input  logic              memReadReq,
    input  logic              memWriteReq,
    input  logic [ADDR_W-1:0] memAddress,
    input  logic [DATA_W-1:0] memWriteData,
    output logic [DATA_W-1:0] memReadData,
    output logic              memReady,
    output logic              ramEn,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [DATA_W-1:0] ramWData,
    input  logic [DATA_W-1:0] ramRData
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          counter_q, counter_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic   data_req;
    owner_t grant;

    assign data_req = memReadReq | memWriteReq;

    always_comb begin
`ifdef ROUND_ROBIN_EN
        if (data_req && ifReq) begin
            grant = (last_owner_q == DATA) ? FETCH : DATA;
        end else begin
            grant = data_req ? DATA : FETCH;
        end
`else
        grant = data_req ? DATA : FETCH;
`endif
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (data_req || ifReq) begin
                    owner_d   = grant;
                    addr_d    = (grant == DATA) ? memAddress : ifAddress;
                    wdata_d   = (grant == DATA) ? memWriteData : '0;
                    we_d      = (grant == DATA) && memWriteReq;
                    counter_d = CNT_LOAD;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (counter_q == 4'd0) begin
                    // ramRData is only guaranteed valid on the final access cycle.
                    if (!we_q) begin
                        if (owner_q == FETCH) begin
                            if_data_d = ramRData;
                        end else begin
                            mem_rdata_d = ramRData;
                        end
                    end
                    state_d = DONE;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            owner_q      <= FETCH;
            last_owner_q <= FETCH;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            if_data_q    <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for a clock.
    assign ramEn       = (state_q == ACCESS);
    assign ramWe       = ramEn && we_q;
    assign ramAddress  = addr_q;
    assign ramWData    = wdata_q;
    assign ifReady     = (state_q == DONE) && (owner_q == FETCH);
    assign memReady    = (state_q == DONE) && (owner_q == DATA);
    assign ifData      = if_data_q;
    assign memReadData = mem_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus hand-written
// sequences for contention, reset during an access and the single-wait-cycle build.
module tb_unified_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq, memReadReq, memWriteReq;
    logic [31:0] ifAddress, memAddress, memWriteData, ramRData;

    logic [31:0] ifData, memReadData, ramAddress, ramWData;
    logic        ifReady, memReady, ramEn, ramWe;

    logic [31:0] ifData1, memReadData1, ramAddress1, ramWData1;
    logic        ifReady1, memReady1, ramEn1, ramWe1;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddress(ifAddress), .ifData(ifData), .ifReady(ifReady),
        .memReadReq(memReadReq), .memWriteReq(memWriteReq), .memAddress(memAddress),
        .memWriteData(memWriteData), .memReadData(memReadData), .memReady(memReady),
        .ramEn(ramEn), .ramWe(ramWe), .ramAddress(ramAddress), .ramWData(ramWData),
        .ramRData(ramRData)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddress(ifAddress), .ifData(ifData1), .ifReady(ifReady1),
        .memReadReq(memReadReq), .memWriteReq(memWriteReq), .memAddress(memAddress),
        .memWriteData(memWriteData), .memReadData(memReadData1), .memReady(memReady1),
        .ramEn(ramEn1), .ramWe(ramWe1), .ramAddress(ramAddress1), .ramWData(ramWData1),
        .ramRData(ramRData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_req, mem_rd, mem_wr;
        logic [31:0] if_addr, mem_addr, wdata, rdata;
        logic        e_en, e_we, e_if_rdy, e_mem_rdy;
        logic [31:0] e_addr, e_wdata, e_if_data, e_mem_rdata;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, mr, mw,
                                input logic [31:0] ia, ma, wd, rd,
                                input logic en, we, irdy, mrdy,
                                input logic [31:0] ea, ew, eid, emd);
        vec_t v;
        v = '{ir, mr, mw, ia, ma, wd, rd, en, we, irdy, mrdy, ea, ew, eid, emd};
        return v;
    endfunction

    task automatic idle_inputs();
        ifReq = L; memReadReq = L; memWriteReq = L;
        ifAddress = '0; memAddress = '0; memWriteData = '0; ramRData = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves both DUTs in IDLE at a falling edge; the caller's next cycle is cycle 0.
    task automatic do_reset();
        idle_inputs();
        rst = H;
        next_cycle();
        rst = L;
    endtask

    vec_t vecs[17];

    initial begin
        // Contention (DATA first), then a fetch, then a store; requests change mid-access.
        vecs[0]  = mk(H,H,L, 32'h20,32'h404,32'h0,32'h0BADF00D,        L,L,L,L, 32'h0,32'h0, 32'h0,32'h0);
        vecs[1]  = mk(H,H,L, 32'h20,32'h404,32'h0,32'h0BADF00D,        H,L,L,L, 32'h404,32'h0, 32'h0,32'h0);
        vecs[2]  = mk(H,H,L, 32'h20,32'h999,32'h0,32'h0BADF00D,        H,L,L,L, 32'h404,32'h0, 32'h0,32'h0);
        vecs[3]  = mk(H,L,L, 32'h20,32'h404,32'h0,32'hCAFEBABE,        L,L,L,H, 32'h0,32'h0, 32'h0,32'h0BADF00D);
        vecs[4]  = mk(H,L,L, 32'h20,32'h404,32'h0,32'hCAFEBABE,        L,L,L,L, 32'h0,32'h0, 32'h0,32'h0BADF00D);
        vecs[5]  = mk(H,L,L, 32'h20,32'h404,32'h0,32'hCAFEBABE,        H,L,L,L, 32'h20,32'h0, 32'h0,32'h0BADF00D);
        vecs[6]  = mk(H,L,L, 32'h20,32'h404,32'h0,32'hCAFEBABE,        H,L,L,L, 32'h20,32'h0, 32'h0,32'h0BADF00D);
        vecs[7]  = mk(L,L,L, 32'h20,32'h404,32'h0,32'hCAFEBABE,        L,L,H,L, 32'h0,32'h0, 32'hCAFEBABE,32'h0BADF00D);
        vecs[8]  = mk(H,L,L, 32'h10,32'h0,32'h0,32'hE3A00001,          L,L,L,L, 32'h0,32'h0, 32'hCAFEBABE,32'h0BADF00D);
        vecs[9]  = mk(H,L,L, 32'h10,32'h0,32'h0,32'hE3A00001,          H,L,L,L, 32'h10,32'h0, 32'hCAFEBABE,32'h0BADF00D);
        vecs[10] = mk(H,L,L, 32'h77,32'h0,32'h0,32'hE3A00001,          H,L,L,L, 32'h10,32'h0, 32'hCAFEBABE,32'h0BADF00D);
        vecs[11] = mk(L,L,L, 32'h10,32'h0,32'h0,32'hE3A00001,          L,L,H,L, 32'h0,32'h0, 32'hE3A00001,32'h0BADF00D);
        vecs[12] = mk(L,L,H, 32'h0,32'h400,32'hDEADBEEF,32'h55AA55AA,  L,L,L,L, 32'h0,32'h0, 32'hE3A00001,32'h0BADF00D);
        vecs[13] = mk(L,L,H, 32'h0,32'h400,32'hDEADBEEF,32'h55AA55AA,  H,H,L,L, 32'h400,32'hDEADBEEF, 32'hE3A00001,32'h0BADF00D);
        vecs[14] = mk(L,L,L, 32'h0,32'h400,32'hDEADBEEF,32'h55AA55AA,  H,H,L,L, 32'h400,32'hDEADBEEF, 32'hE3A00001,32'h0BADF00D);
        vecs[15] = mk(L,L,L, 32'h0,32'h400,32'hDEADBEEF,32'h55AA55AA,  L,L,L,H, 32'h0,32'h0, 32'hE3A00001,32'h0BADF00D);
        vecs[16] = mk(L,L,L, 32'h0,32'h0,32'h0,32'h0,                  L,L,L,L, 32'h0,32'h0, 32'hE3A00001,32'h0BADF00D);

        rst = H;
        idle_inputs();
        #2;
        check("reset ramEn",       {31'd0, ramEn},    32'd0);
        check("reset ramWe",       {31'd0, ramWe},    32'd0);
        check("reset ifReady",     {31'd0, ifReady},  32'd0);
        check("reset memReady",    {31'd0, memReady}, 32'd0);
        check("reset ramAddress",  ramAddress,        32'd0);
        check("reset ramWData",    ramWData,          32'd0);
        check("reset ifData",      ifData,            32'd0);
        check("reset memReadData", memReadData,       32'd0);
        @(negedge clk);
        rst = L;

        for (int i = 0; i < 17; i++) begin
            ifReq = vecs[i].if_req; memReadReq = vecs[i].mem_rd; memWriteReq = vecs[i].mem_wr;
            ifAddress = vecs[i].if_addr; memAddress = vecs[i].mem_addr;
            memWriteData = vecs[i].wdata; ramRData = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d ramEn", i),    {31'd0, ramEn},    {31'd0, vecs[i].e_en});
            check($sformatf("vec%0d ramWe", i),    {31'd0, ramWe},    {31'd0, vecs[i].e_we});
            check($sformatf("vec%0d ifReady", i),  {31'd0, ifReady},  {31'd0, vecs[i].e_if_rdy});
            check($sformatf("vec%0d memReady", i), {31'd0, memReady}, {31'd0, vecs[i].e_mem_rdy});
            check($sformatf("vec%0d ifData", i),      ifData,      vecs[i].e_if_data);
            check($sformatf("vec%0d memReadData", i), memReadData, vecs[i].e_mem_rdata);
            if (vecs[i].e_en)
                check($sformatf("vec%0d ramAddress", i), ramAddress, vecs[i].e_addr);
            if (vecs[i].e_we)
                check($sformatf("vec%0d ramWData", i), ramWData, vecs[i].e_wdata);
            next_cycle();
        end

        // Both requesters held high continuously: ready pulses at cycles 3, 7, 11.
        do_reset();
        ifReq = H; memReadReq = H; ifAddress = 32'h100; memAddress = 32'h200; ramRData = 32'h0000_0042;
        for (int c = 0; c <= 12; c++) begin
            logic exp_if, exp_mem;
            exp_if  = RR_EN ? (c == 7) : 1'b0;
            exp_mem = RR_EN ? (c == 3 || c == 11) : (c == 3 || c == 7 || c == 11);
            #1;
            check($sformatf("rr c%0d ifReady", c),  {31'd0, ifReady},  {31'd0, exp_if});
            check($sformatf("rr c%0d memReady", c), {31'd0, memReady}, {31'd0, exp_mem});
            if (c == 3 || c == 4 || c == 7 || c == 8)
                check($sformatf("rr c%0d ramEn", c), {31'd0, ramEn}, 32'd0);
            next_cycle();
        end

        // Reset asserted during the first access cycle of a store.
        do_reset();
        memWriteReq = H; memAddress = 32'h400; memWriteData = 32'hDEADBEEF;
        next_cycle();
        check("abort pre ramWe", {31'd0, ramWe}, 32'd1);
        rst = H;
        #1;
        check("abort ramEn", {31'd0, ramEn}, 32'd0);
        check("abort ramWe", {31'd0, ramWe}, 32'd0);
        idle_inputs();
        next_cycle();
        rst = L;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("abort c%0d memReady", c), {31'd0, memReady}, 32'd0);
            next_cycle();
        end
        memReadReq = H; memAddress = 32'h400; ramRData = 32'h12345678;
        next_cycle();
        memReadReq = L;
        next_cycle();
        check("reload c2 memReadData", memReadData, 32'd0);
        next_cycle();
        check("reload c3 memReady",    {31'd0, memReady}, 32'd1);
        check("reload c3 memReadData", memReadData, 32'h12345678);

        // Single wait cycle instance: one ramEn cycle, ready one cycle later.
        do_reset();
        memReadReq = H; memAddress = 32'h80; ramRData = 32'hA5A5_0001;
        #1;
        check("w1 c0 ramEn", {31'd0, ramEn1}, 32'd0);
        next_cycle();
        memReadReq = L;
        check("w1 c1 ramEn",      {31'd0, ramEn1},    32'd1);
        check("w1 c1 ramAddress", ramAddress1,        32'h80);
        check("w1 c1 memReady",   {31'd0, memReady1}, 32'd0);
        next_cycle();
        check("w1 c2 ramEn",       {31'd0, ramEn1},    32'd0);
        check("w1 c2 memReady",    {31'd0, memReady1}, 32'd1);
        check("w1 c2 memReadData", memReadData1,       32'hA5A5_0001);
        next_cycle();
        check("w1 c3 memReady",    {31'd0, memReady1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
